// File: rtl/quad_encoder.sv
// quad_encoder: synchronised, glitch-filtered 4x quadrature decoder with index latch and illegal-transition flag.
module quad_encoder #(
  parameter int FILTER_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ENC_A,
  input  logic        ENC_B,
  input  logic        ENC_Z,
  input  logic        indexEnable,
  output logic [31:0] position,
  output logic [31:0] indexPosition,
  output logic        indexLatched,
  output logic        encError
);
  localparam int PRIME = FILTER_LEN + 3;
  logic [2:0]  r_s1, r_s2, r_filt, r_prev;
  logic [7:0]  r_cnt [3];
  logic [8:0]  r_prime;
  logic [31:0] r_position, r_index_pos;
  logic        r_latched, r_error;
  logic [3:0]  w_trans;
  logic        w_live, w_fwd, w_rev, w_ill, w_zrise;
  assign position      = r_position;
  assign indexPosition = r_index_pos;
  assign indexLatched  = r_latched;
  assign encError      = r_error;
  // bit 2 = A, bit 1 = B, bit 0 = Z
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_filt <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_s1 <= {ENC_A, ENC_B, ENC_Z};
      r_s2 <= r_s1;
      for (int i = 0; i < 3; i++)
        if (r_s2[i] == r_filt[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == 8'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + 8'd1;
    end
  assign w_trans = {r_prev[2:1], r_filt[2:1]};
  assign w_fwd   = w_trans == 4'b0001 || w_trans == 4'b0111 || w_trans == 4'b1110 || w_trans == 4'b1000;
  assign w_rev   = w_trans == 4'b0010 || w_trans == 4'b1011 || w_trans == 4'b1101 || w_trans == 4'b0100;
  assign w_ill   = (r_prev[2:1] ^ r_filt[2:1]) == 2'b11;
  assign w_live  = r_prime == 9'(PRIME);
  assign w_zrise = r_filt[0] & ~r_prev[0];
  // prev always follows filt so the first live cycle compares against settled pins
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_prev <= '0;
      r_prime <= '0;
      r_position <= '0;
      r_error <= 1'b0;
    end else begin
      r_prev <= r_filt;
      if (!w_live) r_prime <= r_prime + 9'd1;
      if (w_live && w_fwd) r_position <= r_position + 32'd1;
      else if (w_live && w_rev) r_position <= r_position - 32'd1;
      if (w_live && w_ill) r_error <= 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_index_pos <= '0;
      r_latched <= 1'b0;
    end else if (!indexEnable) r_latched <= 1'b0;
    else if (w_zrise && !r_latched) begin
      r_index_pos <= r_position;
      r_latched <= 1'b1;
    end
endmodule
